// File: rtl/dmem_bus_ctrl_if.sv
// rtl/dmem_bus_ctrl_if.sv - bus and RAM signal bundle for the data-memory access sequencer
//   master: request side and RAM read data (drives START_RD/START_WR/ADDR_IN/DATA_IN/LEN/MEM_RDATA)
//   slave : the sequencer (drives MEM_ADDR/MEM_RE/MEM_WE/MEM_WDATA/BOUT/DEST_WR/BUSY/DONE)
interface dmem_bus_ctrl_if #(
    parameter int DW = 16,
    parameter int AW = 16
);
    logic          START_RD;
    logic          START_WR;
    logic [AW-1:0] ADDR_IN;
    logic [DW-1:0] DATA_IN;
    logic [3:0]    LEN;
    logic [AW-1:0] MEM_ADDR;
    logic          MEM_RE;
    logic          MEM_WE;
    logic [DW-1:0] MEM_WDATA;
    logic [DW-1:0] MEM_RDATA;
    logic [DW-1:0] BOUT;
    logic          DEST_WR;
    logic          BUSY;
    logic          DONE;

    modport master (
        output START_RD, START_WR, ADDR_IN, DATA_IN, LEN, MEM_RDATA,
        input  MEM_ADDR, MEM_RE, MEM_WE, MEM_WDATA, BOUT, DEST_WR, BUSY, DONE
    );

    modport slave (
        input  START_RD, START_WR, ADDR_IN, DATA_IN, LEN, MEM_RDATA,
        output MEM_ADDR, MEM_RE, MEM_WE, MEM_WDATA, BOUT, DEST_WR, BUSY, DONE
    );
endinterface

// File: rtl/dmem_bus_ctrl.sv
// rtl/dmem_bus_ctrl.sv - data-memory access sequencer: single writes and 1-16 word read bursts
//   clk : clock, rising edge
//   RST : synchronous active-high reset, aborts any operation in flight
//   bus : dmem_bus_ctrl_if.slave (start requests, RAM port, BOUT/DEST_WR to the bus, BUSY/DONE)
module dmem_bus_ctrl #(
    parameter int DW     = 16,
    parameter int AW     = 16,
    parameter int RD_LAT = 2
) (
    input  logic            clk,
    input  logic            RST,
    dmem_bus_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        RD_ISSUE,
        RD_WAIT,
        RD_DELIVER
    } state_t;

    localparam logic [2:0] LAT_INIT = 3'(RD_LAT);

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [3:0]    len_q;
    logic [2:0]    lat_q;
    logic [DW-1:0] bout_q;
    logic          done_q, done_d;
    logic          mem_re, mem_we, dest_wr;

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        mem_re  = 1'b0;
        mem_we  = 1'b0;
        dest_wr = 1'b0;
        case (state_q)
            IDLE: begin
                // Read has priority when both starts arrive together.
                if (bus.START_RD)
                    state_d = RD_ISSUE;
                else if (bus.START_WR)
                    state_d = WR_ISSUE;
            end
            WR_ISSUE: begin
                mem_we  = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            RD_ISSUE: begin
                mem_re  = 1'b1;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                // lat_q reaches 1 in the cycle MEM_RDATA becomes valid.
                if (lat_q == 3'd1)
                    state_d = RD_DELIVER;
            end
            RD_DELIVER: begin
                dest_wr = 1'b1;
                if (len_q == 4'd0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = RD_ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            addr_q  <= '0;
            wdata_q <= '0;
            len_q   <= '0;
            lat_q   <= '0;
            bout_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.START_RD) begin
                        addr_q <= bus.ADDR_IN;
                        len_q  <= bus.LEN;
                    end else if (bus.START_WR) begin
                        addr_q  <= bus.ADDR_IN;
                        wdata_q <= bus.DATA_IN;
                    end
                end
                RD_ISSUE: lat_q <= LAT_INIT;
                RD_WAIT: begin
                    lat_q <= lat_q - 3'd1;
                    if (lat_q == 3'd1)
                        bout_q <= bus.MEM_RDATA;
                end
                RD_DELIVER: begin
                    // Address wraps naturally modulo 2^AW.
                    if (len_q != 4'd0) begin
                        len_q  <= len_q - 4'd1;
                        addr_q <= addr_q + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // MEM_ADDR is the latched address, so it holds between accesses.
    assign bus.MEM_ADDR  = addr_q;
    assign bus.MEM_RE    = mem_re;
    assign bus.MEM_WE    = mem_we;
    assign bus.MEM_WDATA = mem_we ? wdata_q : '0;
    assign bus.BOUT      = bout_q;
    assign bus.DEST_WR   = dest_wr;
    assign bus.BUSY      = (state_q != IDLE);
    assign bus.DONE      = done_q;
endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// tb/tb_dmem_bus_ctrl.sv - self-checking bench for dmem_bus_ctrl
module tb_dmem_bus_ctrl;
    localparam int DW     = 16;
    localparam int AW     = 16;
    localparam int RD_LAT = 2;
    localparam int PER    = RD_LAT + 2;

    logic clk = 1'b0;
    logic RST;
    always #5 clk = ~clk;

    dmem_bus_ctrl_if #(.DW(DW), .AW(AW)) bus ();

    dmem_bus_ctrl #(.DW(DW), .AW(AW), .RD_LAT(RD_LAT)) dut (
        .clk (clk),
        .RST (RST),
        .bus (bus)
    );

    // RAM with RD_LAT read latency; poison value when no read was issued.
    logic [DW-1:0] ram     [0:65535];
    logic [DW-1:0] ref_mem [0:65535];
    logic [DW-1:0] pipe    [1:RD_LAT];
    always @(posedge clk) begin
        if (bus.MEM_WE) ram[bus.MEM_ADDR] <= bus.MEM_WDATA;
        pipe[1] <= bus.MEM_RE ? ram[bus.MEM_ADDR] : 16'hDEAD;
        for (int k = 2; k <= RD_LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign bus.MEM_RDATA = pipe[RD_LAT];

    // Destination register loaded by DEST_WR.
    logic [DW-1:0] r3467;
    always @(posedge clk) begin
        if (RST) r3467 <= '0;
        else if (bus.DEST_WR) r3467 <= bus.BOUT;
    end

    logic [4:0] status;
    assign status = {bus.BUSY, bus.DONE, bus.MEM_RE, bus.MEM_WE, bus.DEST_WR};

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.START_RD = 1'b0;
        bus.START_WR = 1'b0;
    endtask

    // Each task starts and ends just after a negedge sample point.
    task automatic run_write(input logic [15:0] addr, input logic [15:0] data);
        bus.START_WR = 1'b1;
        bus.ADDR_IN  = addr;
        bus.DATA_IN  = data;
        for (int t = 1; t <= 2; t++) begin
            @(negedge clk);
            check("wr_status", 32'(status), 32'({t == 1, t == 2, 1'b0, t == 1, 1'b0}));
            if (t == 1) begin
                check("wr_addr", 32'(bus.MEM_ADDR), 32'(addr));
                check("wr_data", 32'(bus.MEM_WDATA), 32'(data));
            end else begin
                check("wr_data_idle", 32'(bus.MEM_WDATA), 32'h0);
            end
            clear_inputs();
        end
        ref_mem[addr] = data;
    endtask

    task automatic run_read(input logic [15:0] addr, input int len, input bit both, input int inj);
        int last;
        int k;
        logic re_e, dw_e;
        logic [15:0] a;
        last = (len + 1) * PER + 1;
        bus.START_RD = 1'b1;
        bus.ADDR_IN  = addr;
        bus.LEN      = 4'(len);
        if (both) begin
            bus.START_WR = 1'b1;
            bus.DATA_IN  = 16'h5A5A;
        end
        for (int t = 1; t <= last; t++) begin
            @(negedge clk);
            re_e = ((t - 1) % PER == 0) && (t < last);
            dw_e = (t % PER == 0) && (t < last);
            check("rd_status", 32'(status), 32'({t < last, t == last, re_e, 1'b0, dw_e}));
            check("rd_wdata_zero", 32'(bus.MEM_WDATA), 32'h0);
            if (re_e) begin
                k = (t - 1) / PER;
                a = addr + 16'(k);
                check("rd_addr", 32'(bus.MEM_ADDR), 32'(a));
            end
            if (dw_e) begin
                k = t / PER - 1;
                a = addr + 16'(k);
                check("rd_bout", 32'(bus.BOUT), 32'(ref_mem[a]));
            end
            if (t == last) begin
                a = addr + 16'(len);
                check("rd_r3467", 32'(r3467), 32'(ref_mem[a]));
                check("rd_addr_hold", 32'(bus.MEM_ADDR), 32'(a));
            end
            clear_inputs();
            if (t == inj) begin
                bus.START_WR = 1'b1;
                bus.ADDR_IN  = 16'($urandom);
                bus.DATA_IN  = 16'($urandom);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            check("idle_status", 32'(status), 32'h0);
            check("idle_wdata", 32'(bus.MEM_WDATA), 32'h0);
        end
    endtask

    initial begin
        logic [15:0] a;
        RST = 1'b1;
        bus.START_RD = 1'b0;
        bus.START_WR = 1'b0;
        bus.ADDR_IN  = '0;
        bus.DATA_IN  = '0;
        bus.LEN      = '0;
        for (int i = 0; i < 32; i++) begin
            a = 16'hFFF0 + 16'(i);
            ram[a]     = 16'($urandom);
            ref_mem[a] = ram[a];
        end
        ram[16'h0040] = 16'h0000;
        ref_mem[16'h0040] = 16'h0000;

        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_status", 32'(status), 32'h0);
            check("rst_addr", 32'(bus.MEM_ADDR), 32'h0);
            check("rst_bout", 32'(bus.BOUT), 32'h0);
            check("rst_wdata", 32'(bus.MEM_WDATA), 32'h0);
        end
        RST = 1'b0;

        // Single write, then a read started in the DONE cycle.
        run_write(16'h0040, 16'hBEEF);
        run_read(16'h0040, 0, 1'b0, 0);
        check("r3467_beef", 32'(r3467), 32'hBEEF);

        // Burst crossing the top of the address space.
        ram[16'hFFFE] = 16'd1; ref_mem[16'hFFFE] = 16'd1;
        ram[16'hFFFF] = 16'd2; ref_mem[16'hFFFF] = 16'd2;
        ram[16'h0000] = 16'd3; ref_mem[16'h0000] = 16'd3;
        run_read(16'hFFFE, 2, 1'b0, 0);

        // Simultaneous start and a write request during a burst.
        run_read(16'h0040, 0, 1'b1, 0);
        idle(3);
        run_read(16'hFFF4, 3, 1'b0, 6);
        idle(4);

        // Reset in the second RD_WAIT of a 6-word burst.
        bus.START_RD = 1'b1;
        bus.ADDR_IN  = 16'hFFF2;
        bus.LEN      = 4'd5;
        repeat (6) begin
            @(negedge clk);
            clear_inputs();
        end
        RST = 1'b1;
        @(negedge clk);
        check("abort_status", 32'(status), 32'h0);
        check("abort_bout", 32'(bus.BOUT), 32'h0);
        RST = 1'b0;
        idle(3);
        run_read(16'h0040, 0, 1'b0, 0);

        // Randomized mix of operations over a window that wraps.
        for (int i = 0; i < 30; i++) begin
            a = 16'hFFF0 + 16'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1)
                run_write(a, 16'($urandom));
            else
                run_read(a, int'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), 0);
            if ($urandom_range(0, 2) == 0)
                idle(int'($urandom_range(1, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
